sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the single-port SDRAM controller. Each
//  requester presents one read or write command; the arbiter latches it, sequences the
//  controller enable/busy/rd_ready handshake and returns completion (plus read data).
//  Sits between the clock-crossing fifos of each client and the SDRAM controller, one clock.
// PARAMETERS
//  ADDR_WIDTH     24  SDRAM word address width
//  DATA_WIDTH     16  SDRAM data width
//  ISSUE_TIMEOUT  15  max cycles in ISSUE waiting for sd_busy before abort (>=1, 4-bit counter)
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rst          in   1           asynchronous reset, active-high
//  p0_req       in   1           port 0 command valid; held with cmd fields until p0_ack
//  p0_we        in   1           port 0: 1=write, 0=read
//  p0_addr      in   ADDR_WIDTH  port 0 address
//  p0_wdata     in   DATA_WIDTH  port 0 write data
//  p0_ack       out  1           port 0 one-cycle completion pulse
//  p0_rdata     out  DATA_WIDTH  port 0 read data, valid from p0_ack, held until next port-0 read
//  p1_*         --   --          identical set for port 1 (req, we, addr, wdata, ack, rdata)
//  grant        out  2           one-hot owner of the controller, 2'b00 when idle
//  timeout      out  1           one-cycle pulse: issued command aborted (no sd_busy seen)
//  sd_wr_enable out  1           controller write strobe
//  sd_wr_addr   out  ADDR_WIDTH  controller write address
//  sd_wr_data   out  DATA_WIDTH  controller write data
//  sd_rd_enable out  1           controller read strobe
//  sd_rd_addr   out  ADDR_WIDTH  controller read address
//  sd_rd_data   in   DATA_WIDTH  controller read data, valid with sd_rd_ready
//  sd_rd_ready  in   1           controller read data valid pulse
//  sd_busy      in   1           controller executing a command
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, prio=0, all outputs 0 incl. rdata regs, sd_* strobes.
//    Reset mid-transaction drops strobes at once; no ack, no timeout pulse.
//  - FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, registered outputs only.
//  - IDLE: if sd_busy==0 and any req: winner = sole requester, or port `prio` if both.
//    Latch we/addr/wdata of winner, set grant, tmo_cnt=0 -> ISSUE. sd_busy==1: stay.
//  - ISSUE: strobe (sd_wr_enable if we else sd_rd_enable) high with latched addr/data,
//    first high the cycle after the IDLE decision. On sd_busy==1: drop strobe -> WAIT.
//    tmo_cnt increments per cycle; at tmo_cnt==ISSUE_TIMEOUT without busy: drop strobe,
//    pulse timeout, -> DONE (ack still pulses, rdata unchanged).
//  - WAIT write: sd_busy==0 -> DONE. WAIT read: sd_rd_ready==1 -> capture sd_rd_data into
//    granted port's rdata -> DONE (sd_busy level ignored; IDLE re-checks it).
//  - DONE: granted port's ack=1 for exactly this cycle, grant->0, prio = other port, -> IDLE.
//  - Fairness: prio toggles after every completion; both ports held requesting alternate
//    p0,p1,p0,... Min turnaround req-seen to next arbitration = 4 cycles + controller time.
//  - req dropping mid-transaction is ignored; command completes and acks.
//  - Command fields sampled only in IDLE; changes afterwards have no effect.
//  - sd_rd_ready outside read WAIT ignored. Never both strobes, never both ack bits high.
// TESTING
//  - Reset: rst=1 mid-ISSUE -> sd_wr_enable/grant/acks 0 same cycle; after release, IDLE.
//  - p0 write addr 24'h000010 data 16'hA5A5; model busy 1 cycle after strobe for 5 cycles ->
//    sd_wr_enable 1 cycle, sd_wr_addr=0x10, p0_ack pulse after busy falls, grant 2'b01.
//  - p1 read addr 0x20, model returns 16'h1234 with sd_rd_ready -> p1_rdata=0x1234 at p1_ack.
//  - p0 and p1 request together, held for 4 completions -> grant order 01,10,01,10.
//  - Model never asserts busy -> strobe held ISSUE_TIMEOUT cycles, timeout+ack pulse, no hang.
//  - sd_busy high in IDLE with req -> no strobe until busy low; then strobe next cycle.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port SDRAM controller.
// One command per port is latched in IDLE, strobed to the controller in ISSUE,
// tracked through WAIT and acknowledged to the owning port in DONE.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 16,
  parameter int ISSUE_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [1:0]            grant,
  output logic                  timeout,
  output logic                  sd_wr_enable,
  output logic [ADDR_WIDTH-1:0] sd_wr_addr,
  output logic [DATA_WIDTH-1:0] sd_wr_data,
  output logic                  sd_rd_enable,
  output logic [ADDR_WIDTH-1:0] sd_rd_addr,
  input  logic [DATA_WIDTH-1:0] sd_rd_data,
  input  logic                  sd_rd_ready,
  input  logic                  sd_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] TMO_LIMIT = 4'(ISSUE_TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic                  prio_q, prio_d;
  logic [1:0]            grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            tmo_cnt_q, tmo_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  sel1;
  logic                  sel_we;

  // Next-state and output-register computation for the arbitration FSM.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tmo_cnt_d = tmo_cnt_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    timeout_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    // Port 1 wins when it is the sole requester, or both request and it holds priority.
    sel1      = p1_req && (!p0_req || prio_q);
    sel_we    = sel1 ? p1_we : p0_we;
    case (state_q)
      S_IDLE: begin
        if (!sd_busy && (p0_req || p1_req)) begin
          we_d      = sel_we;
          addr_d    = sel1 ? p1_addr  : p0_addr;
          wdata_d   = sel1 ? p1_wdata : p0_wdata;
          grant_d   = sel1 ? 2'b10 : 2'b01;
          tmo_cnt_d = 4'd0;
          wr_en_d   = sel_we;
          rd_en_d   = !sel_we;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_cnt_d = tmo_cnt_q + 4'd1;
        if (sd_busy) begin
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          state_d = S_WAIT;
        end else if (tmo_cnt_d == TMO_LIMIT) begin
          // Controller never accepted: abandon, but still complete to the port.
          wr_en_d   = 1'b0;
          rd_en_d   = 1'b0;
          timeout_d = 1'b1;
          ack0_d    = grant_q[0];
          ack1_d    = grant_q[1];
          state_d   = S_DONE;
        end
      end
      S_WAIT: begin
        if (we_q ? !sd_busy : sd_rd_ready) begin
          if (!we_q && grant_q[0]) rdata0_d = sd_rd_data;
          if (!we_q && grant_q[1]) rdata1_d = sd_rd_data;
          ack0_d  = grant_q[0];
          ack1_d  = grant_q[1];
          state_d = S_DONE;
        end
      end
      default: begin
        grant_d = 2'b00;
        prio_d  = grant_q[0];
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      prio_q    <= 1'b0;
      grant_q   <= 2'b00;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tmo_cnt_q <= 4'd0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      timeout_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tmo_cnt_q <= tmo_cnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      timeout_q <= timeout_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign p0_ack       = ack0_q;
  assign p1_ack       = ack1_q;
  assign p0_rdata     = rdata0_q;
  assign p1_rdata     = rdata1_q;
  assign grant        = grant_q;
  assign timeout      = timeout_q;
  assign sd_wr_enable = wr_en_q;
  assign sd_rd_enable = rd_en_q;
  assign sd_wr_addr   = addr_q;
  assign sd_rd_addr   = addr_q;
  assign sd_wr_data   = wdata_q;

endmodule
